// File: rtl/udp_frame_sequencer_pkg.sv
// Shared Ethernet/IPv4/UDP field constants, section lengths and CRC helpers
// for the UDP frame sequencer.
package udp_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } seq_state_e;

  localparam int PREAMBLE_LEN = 8;
  localparam int HEADER_LEN   = 42;
  localparam int FCS_LEN      = 4;
  localparam int DEFAULT_PAYLOAD_LEN = 18;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [47:0] DST_MAC    = 48'h000A35010203;
  localparam logic [47:0] SRC_MAC    = 48'h000A35040506;
  localparam logic [15:0] ETHER_TYPE = 16'h0800;

  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [15:0] IP_ID         = 16'h0000;
  localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
  localparam logic [7:0]  IP_TTL        = 8'h40;
  localparam logic [7:0]  IP_PROTO      = 8'h11;
  localparam logic [31:0] IP_SRC        = 32'hC0A8010A;
  localparam logic [31:0] IP_DST        = 32'hC0A80114;

  localparam logic [15:0] UDP_SRC_PORT = 16'h1234;
  localparam logic [15:0] UDP_DST_PORT = 16'h5678;
  localparam logic [15:0] UDP_CSUM     = 16'h0000;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [15:0] ip_total_len(input int unsigned plen);
    return 16'(28 + plen);
  endfunction

  function automatic logic [15:0] udp_len(input int unsigned plen);
    return 16'(8 + plen);
  endfunction

  // One's-complement sum of the IPv4 header words, checksum field as zero.
  function automatic logic [15:0] ip_csum(input int unsigned plen);
    logic [31:0] s;
    s = 32'({IP_VER_IHL, IP_TOS}) + 32'(ip_total_len(plen))
      + 32'(IP_ID) + 32'(IP_FLAGS_FRAG)
      + 32'({IP_TTL, IP_PROTO})
      + 32'(IP_SRC[31:16]) + 32'(IP_SRC[15:0])
      + 32'(IP_DST[31:16]) + 32'(IP_DST[15:0]);
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  // Whole 42-byte header, first wire byte in the top bits.
  function automatic logic [335:0] header_vec(input int unsigned plen);
    return {DST_MAC, SRC_MAC, ETHER_TYPE,
            IP_VER_IHL, IP_TOS, ip_total_len(plen),
            IP_ID, IP_FLAGS_FRAG, IP_TTL, IP_PROTO,
            ip_csum(plen), IP_SRC, IP_DST,
            UDP_SRC_PORT, UDP_DST_PORT,
            udp_len(plen), UDP_CSUM};
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // FCS of the default header followed by the default counting payload
  // 0x00..0x11; only valid for that exact frame.
  function automatic logic [31:0] default_fcs();
    logic [335:0] h;
    logic [31:0] c;
    h = header_vec(DEFAULT_PAYLOAD_LEN);
    c = CRC_INIT;
    for (int i = 0; i < HEADER_LEN; i++)
      c = crc32_byte(c, h[8*(HEADER_LEN-1-i) +: 8]);
    for (int i = 0; i < DEFAULT_PAYLOAD_LEN; i++)
      c = crc32_byte(c, 8'(i));
    return ~c;
  endfunction

  localparam logic [31:0] ETHER_FCS = default_fcs();
  localparam logic [7:0] ETHER_CHECKSUM_0 = ETHER_FCS[7:0];
  localparam logic [7:0] ETHER_CHECKSUM_1 = ETHER_FCS[15:8];
  localparam logic [7:0] ETHER_CHECKSUM_2 = ETHER_FCS[23:16];
  localparam logic [7:0] ETHER_CHECKSUM_3 = ETHER_FCS[31:24];

endpackage

// File: rtl/udp_frame_sequencer_crc.sv
// Byte-wide reflected CRC32 next-state function (crc32_d8).
// Purely combinational; one data byte per call.
module crc32_d8
  import udp_frame_sequencer_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [31:0] crc_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // Shift eight data bits through the LSB-first CRC register.
  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    crc_o = c;
  end

endmodule

// File: rtl/udp_frame_sequencer.sv
// Ethernet/IPv4/UDP frame sequencer for the 8-bit PHY TX path.
// Define UDP_FRAME_SEQUENCER_CRC_GEN_EN for a live FCS; else static FCS.
module udp_frame_sequencer
  import udp_frame_sequencer_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 18,
  parameter int unsigned IFG_LEN     = 12
) (
  input  logic       i_clock_data,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_pay_data,
  input  logic       i_pay_valid,
  output logic       o_pay_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

  localparam logic [10:0] K_HDR  = 11'(PREAMBLE_LEN);
  localparam logic [10:0] K_PAY  = 11'(PREAMBLE_LEN + HEADER_LEN);
  localparam logic [10:0] K_FCS  = 11'(PREAMBLE_LEN + HEADER_LEN
                                       + PAYLOAD_LEN);
  localparam logic [10:0] K_LAST = 11'(PREAMBLE_LEN + HEADER_LEN
                                       + PAYLOAD_LEN + FCS_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
  localparam logic [335:0] HDR = header_vec(PAYLOAD_LEN);

  seq_state_e  state_q;
  logic [10:0] k_q;
  logic [7:0]  ifg_q;
  logic [31:0] crc_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic        busy_q;
  logic        done_q;
  logic        und_q;
  logic        rdy_q;

  logic        start_frame;
  logic [10:0] idx_d;
  logic [7:0]  pay_byte;
  logic [5:0]  hdr_sel;
  logic [1:0]  fcs_off;
  logic [31:0] fcs_word;
  logic [7:0]  byte_d;
  logic        in_crc;
  logic        rdy_d;
  logic [31:0] crc_next;

`ifdef UDP_FRAME_SEQUENCER_CRC_GEN_EN
  assign fcs_word = ~crc_q;
`else
  assign fcs_word = {ETHER_CHECKSUM_3, ETHER_CHECKSUM_2,
                     ETHER_CHECKSUM_1, ETHER_CHECKSUM_0};
`endif

  // Index and value of the byte that goes on the bus at the next edge.
  always_comb begin
    start_frame = i_start &
                  ((state_q == ST_IDLE) |
                   ((state_q == ST_IFG) & (ifg_q == IFG_LAST)));
    idx_d    = start_frame ? 11'd0 : k_q + 11'd1;
    pay_byte = i_pay_valid ? i_pay_data : 8'h00;
    hdr_sel  = 6'(K_PAY - 11'd1 - idx_d);
    fcs_off  = 2'(idx_d - K_FCS);
    in_crc   = (idx_d >= K_HDR) && (idx_d < K_FCS);
    rdy_d    = (idx_d >= K_PAY - 11'd1) && (idx_d < K_FCS - 11'd1);
    byte_d   = 8'h00;
    unique case (1'b1)
      (idx_d < 11'd7):
        byte_d = PREAMBLE_BYTE;
      (idx_d == 11'd7):
        byte_d = SFD_BYTE;
      (idx_d >= K_HDR && idx_d < K_PAY):
        byte_d = HDR[{hdr_sel, 3'b000} +: 8];
      (idx_d >= K_PAY && idx_d < K_FCS):
        byte_d = pay_byte;
      default:
        byte_d = fcs_word[{fcs_off, 3'b000} +: 8];
    endcase
  end

  crc32_d8 u_crc (
    .data_i (byte_d),
    .crc_i  (crc_q),
    .crc_o  (crc_next)
  );

  // Frame scheduler: section sequencing, IFG timing, registered outputs.
  always_ff @(posedge i_clock_data) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      ifg_q     <= '0;
      crc_q     <= CRC_INIT;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      und_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      und_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_IFG: begin
          if (start_frame) begin
            state_q   <= ST_PREAMBLE;
            k_q       <= '0;
            ifg_q     <= '0;
            crc_q     <= CRC_INIT;
            tx_data_q <= byte_d;
            tx_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else if (state_q == ST_IFG && ifg_q != IFG_LAST) begin
            ifg_q <= ifg_q + 8'd1;
          end else begin
            state_q <= ST_IDLE;
            ifg_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (k_q == K_LAST) begin
            state_q   <= ST_IFG;
            k_q       <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
          end else begin
            k_q       <= idx_d;
            tx_data_q <= byte_d;
            und_q     <= rdy_q & ~i_pay_valid;
            done_q    <= (idx_d == K_LAST);
            rdy_q     <= rdy_d;
            if (in_crc)
              crc_q <= crc_next;
            if (idx_d < K_HDR)
              state_q <= ST_PREAMBLE;
            else if (idx_d < K_PAY)
              state_q <= ST_HEADER;
            else if (idx_d < K_FCS)
              state_q <= ST_PAYLOAD;
            else
              state_q <= ST_FCS;
          end
        end
      endcase
    end
  end

  assign o_pay_ready  = rdy_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_en      = tx_en_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_underrun   = und_q;

endmodule

// File: tb/tb_udp_frame_sequencer.sv
// Directed bench for udp_frame_sequencer (PAYLOAD_LEN 18, IFG_LEN 12).
// Vector table plus hand sequences for reset, underrun and back-to-back.
module tb_udp_frame_sequencer;

  localparam int NC = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pdata;
  logic       pvalid;
  logic       rdy;
  logic [7:0] txd;
  logic       txen;
  logic       busy;
  logic       done;
  logic       und;

  int checks = 0;
  int failures = 0;

  logic       en_a   [NC];
  logic [7:0] dat_a  [NC];
  logic       done_a [NC];
  logic       und_a  [NC];
  logic       busy_a [NC];
  logic       rdy_a  [NC];

  logic [7:0]  hdr_exp [42];
  logic [31:0] exp_fcs;

  typedef struct {
    int         drop;
    int         k;
    logic [7:0] data;
    logic       und;
  } vec_t;

  vec_t tbl [24];

  always #5 clk = ~clk;

  udp_frame_sequencer #(
    .PAYLOAD_LEN (18),
    .IFG_LEN     (12)
  ) dut (
    .i_clock_data (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_pay_data   (pdata),
    .i_pay_valid  (pvalid),
    .o_pay_ready  (rdy),
    .o_tx_data    (txd),
    .o_tx_en      (txen),
    .o_busy       (busy),
    .o_frame_done (done),
    .o_underrun   (und)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] exp_body(input int k, input int drop);
    if (k < 7) return 8'h55;
    if (k == 7) return 8'hD5;
    if (k < 50) return hdr_exp[k-8];
    if (k - 50 == drop) return 8'h00;
    return 8'(k - 50);
  endfunction

  // Start a frame at the next edge N, record cycles N+1..N+ncyc.
  task automatic run(input int ncyc, input int drop, input int hold);
    int pidx;
    bit took;
    pidx = 0;
    start = 1'b1;
    pvalid = 1'b1;
    pdata = 8'h00;
    @(posedge clk); #1;
    start = (hold > 0);
    for (int c = 1; c <= ncyc; c++) begin
      en_a[c]   = txen;
      dat_a[c]  = txd;
      done_a[c] = done;
      und_a[c]  = und;
      busy_a[c] = busy;
      rdy_a[c]  = rdy;
      took = rdy;
      pdata = 8'(pidx);
      pvalid = (pidx != drop);
      start = (c < hold);
      @(posedge clk); #1;
      if (took) pidx++;
    end
    start = 1'b0;
    pvalid = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    logic [31:0] r;

    hdr_exp = '{
      8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03,
      8'h00, 8'h0A, 8'h35, 8'h04, 8'h05, 8'h06,
      8'h08, 8'h00,
      8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00,
      8'h40, 8'h00, 8'h40, 8'h11, 8'hB7, 8'h50,
      8'hC0, 8'hA8, 8'h01, 8'h0A,
      8'hC0, 8'hA8, 8'h01, 8'h14,
      8'h12, 8'h34, 8'h56, 8'h78,
      8'h00, 8'h1A, 8'h00, 8'h00
    };
    r = 32'hFFFFFFFF;
    for (int k = 8; k < 68; k++) r = crc_upd(r, exp_body(k, -1));
    exp_fcs = ~r;

    tbl = '{
      '{-1,  0, 8'h55, 1'b0}, '{-1,  6, 8'h55, 1'b0},
      '{-1,  7, 8'hD5, 1'b0}, '{-1,  8, 8'h00, 1'b0},
      '{-1, 10, 8'h35, 1'b0}, '{-1, 13, 8'h03, 1'b0},
      '{-1, 19, 8'h06, 1'b0}, '{-1, 20, 8'h08, 1'b0},
      '{-1, 22, 8'h45, 1'b0}, '{-1, 25, 8'h2E, 1'b0},
      '{-1, 28, 8'h40, 1'b0}, '{-1, 32, 8'hB7, 1'b0},
      '{-1, 33, 8'h50, 1'b0}, '{-1, 37, 8'h0A, 1'b0},
      '{-1, 41, 8'h14, 1'b0}, '{-1, 43, 8'h34, 1'b0},
      '{-1, 47, 8'h1A, 1'b0}, '{-1, 50, 8'h00, 1'b0},
      '{-1, 67, 8'h11, 1'b0}, '{ 5, 54, 8'h04, 1'b0},
      '{ 5, 55, 8'h00, 1'b1}, '{ 5, 56, 8'h06, 1'b0},
      '{17, 67, 8'h00, 1'b1}, '{ 0, 50, 8'h00, 1'b1}
    };

    rst = 1'b1;
    start = 1'b0;
    pdata = 8'h00;
    pvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx_en", 32'(txen), 0);
    check("rst tx_data", 32'(txd), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst underrun", 32'(und), 0);
    check("rst pay_ready", 32'(rdy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle tx_en", 32'(txen), 0);

    for (int i = 0; i < 24; i++) begin
      run(90, tbl[i].drop, 0);
      check($sformatf("vec%0d k%0d data", i, tbl[i].k),
            32'(dat_a[tbl[i].k + 1]), 32'(tbl[i].data));
      check($sformatf("vec%0d k%0d underrun", i, tbl[i].k),
            32'(und_a[tbl[i].k + 1]), 32'(tbl[i].und));
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midrst k30 byte", 32'(txd), 32'h40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst tx_en", 32'(txen), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst tx_data", 32'(txd), 0);
    check("midrst pay_ready", 32'(rdy), 0);
    n = 0;
    for (int c = 0; c < 90; c++) begin
      n += int'(done) + int'(txen);
      @(posedge clk); #1;
    end
    check("midrst no done/tx after", n, 0);

    run(90, -1, 0);
    n = 0;
    for (int k = 0; k < 68; k++)
      if (dat_a[k+1] !== exp_body(k, -1)) n++;
    check("frame body mismatches", n, 0);
    for (int j = 0; j < 4; j++)
      check($sformatf("fcs byte %0d", j),
            32'(dat_a[69+j]), 32'(exp_fcs[8*j +: 8]));
    r = 32'hFFFFFFFF;
    for (int k = 8; k < 72; k++) r = crc_upd(r, dat_a[k+1]);
    check("crc residue", r, 32'hDEBB20E3);
    n = 0;
    n2 = 0;
    for (int c = 1; c <= 90; c++) begin
      n += int'(en_a[c]);
      n2 += int'(rdy_a[c]);
    end
    check("tx_en count", n, 72);
    check("tx_en first", 32'(en_a[1]), 1);
    check("tx_en last", 32'(en_a[72]), 1);
    check("tx_en after", 32'(en_a[73]), 0);
    check("pay_ready count", n2, 18);
    check("pay_ready first", 32'(rdy_a[50]), 1);
    check("pay_ready early", 32'(rdy_a[49]), 0);
    check("pay_ready last", 32'(rdy_a[67]), 1);
    n = 0;
    n2 = 0;
    for (int c = 1; c <= 90; c++) begin
      n += int'(done_a[c]);
      n2 += int'(und_a[c]);
    end
    check("frame_done count", n, 1);
    check("frame_done at 72", 32'(done_a[72]), 1);
    check("underrun none", n2, 0);
    check("busy first", 32'(busy_a[1]), 1);
    check("busy last ifg", 32'(busy_a[84]), 1);
    check("busy after ifg", 32'(busy_a[85]), 0);
    n = 0;
    for (int c = 73; c <= 90; c++) n += int'(dat_a[c]);
    check("ifg data zero", n, 0);

    run(90, 5, 0);
    n = 0;
    n2 = 0;
    for (int c = 1; c <= 90; c++) begin
      n += int'(und_a[c]);
      n2 += int'(en_a[c]);
    end
    check("udr pulse count", n, 1);
    check("udr pulse at k55", 32'(und_a[56]), 1);
    check("udr k55 byte", 32'(dat_a[56]), 0);
    check("udr frame length", n2, 72);
    check("udr frame_done", 32'(done_a[72]), 1);

    run(260, -1, 240);
    n = 0;
    n2 = 0;
    for (int c = 1; c <= 260; c++) begin
      bit ee;
      ee = (c <= 72) || (c >= 85 && c <= 156) ||
           (c >= 169 && c <= 240);
      if (en_a[c] !== ee) n++;
      if (busy_a[c] !== (c <= 252)) n2++;
    end
    check("b2b tx_en pattern", n, 0);
    check("b2b busy pattern", n2, 0);
    n = 0;
    for (int c = 1; c <= 260; c++) n += int'(done_a[c]);
    check("b2b done count", n, 3);
    check("b2b done f2", 32'(done_a[156]), 1);
    check("b2b done f3", 32'(done_a[240]), 1);
    check("b2b f2 byte0", 32'(dat_a[85]), 32'h55);
    check("b2b f3 sfd", 32'(dat_a[176]), 32'hD5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
